// File: rtl/m68k_bus_arbiter.sv
// 68000 bus arbitration (BR_n/BG_n/BGACK_n) for external DMA masters, clocked on the c7m falling edge.
// Optional Pi fairness between back-to-back DMA tenures is enabled with `define M68K_ARB_FAIR_EN.
module m68k_bus_arbiter #(
    parameter int SYNC_STAGES     = 2,
    parameter int GRANT_TIMEOUT   = 15,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic       c7m,
    input  logic       reset,
    input  logic       br_n,
    input  logic       bgack_n,
    input  logic       cycle_idle,
    input  logic       op_req_pending,
    output logic       bg_n,
    output logic       hold_req,
    output logic       bus_released,
    output logic [1:0] arb_state
);

    localparam int CNT_MAX = (GRANT_TIMEOUT > RECOVERY_CYCLES) ? GRANT_TIMEOUT : RECOVERY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GRANT_LIM = CNT_W'(GRANT_TIMEOUT);
    localparam logic [CNT_W-1:0] REC_LIM   = CNT_W'(RECOVERY_CYCLES);

    typedef enum logic [2:0] {
        ST_OWN   = 3'd0,
        ST_PEND  = 3'd1,
        ST_GRANT = 3'd2,
        ST_EXT   = 3'd3,
        ST_REC   = 3'd4
    } arb_state_e;

    arb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] br_sync_q, bgack_sync_q;
    logic                   br_s, bgack_s;
    logic                   bg_n_q, hold_req_q, bus_released_q;
    logic [1:0]             arb_state_q;
    logic                   owe_pi_q, owe_pi_d, seen_busy_q, seen_busy_d;

    assign br_s    = br_sync_q[SYNC_STAGES-1];
    assign bgack_s = bgack_sync_q[SYNC_STAGES-1];

`ifndef M68K_ARB_FAIR_EN
    logic unused_op_req_s;
    assign unused_op_req_s = op_req_pending;
`endif

    // State, counters, synchronisers and registered outputs (outputs decoded from next state)
    always_ff @(negedge c7m) begin
        if (reset) begin
            state_q        <= ST_OWN;
            cnt_q          <= '0;
            br_sync_q      <= '1;
            bgack_sync_q   <= '1;
            bg_n_q         <= 1'b1;
            hold_req_q     <= 1'b0;
            bus_released_q <= 1'b0;
            arb_state_q    <= 2'd0;
            owe_pi_q       <= 1'b0;
            seen_busy_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            br_sync_q      <= {br_sync_q[SYNC_STAGES-2:0], br_n};
            bgack_sync_q   <= {bgack_sync_q[SYNC_STAGES-2:0], bgack_n};
            bg_n_q         <= (state_d != ST_GRANT);
            hold_req_q     <= (state_d != ST_OWN);
            bus_released_q <= (state_d == ST_GRANT) || (state_d == ST_EXT) || (state_d == ST_REC);
            owe_pi_q       <= owe_pi_d;
            seen_busy_q    <= seen_busy_d;
            case (state_d)
                ST_OWN:   arb_state_q <= 2'd0;
                ST_PEND:  arb_state_q <= 2'd1;
                ST_GRANT: arb_state_q <= 2'd2;
                default:  arb_state_q <= 2'd3;
            endcase
        end
    end

    // Next-state logic, grant/recovery counter and fairness bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owe_pi_d    = 1'b0;
        seen_busy_d = 1'b0;
`ifdef M68K_ARB_FAIR_EN
        // The debt clears only once the engine has left idle and come back
        owe_pi_d    = owe_pi_q;
        seen_busy_d = seen_busy_q;
        if (owe_pi_q) begin
            if (!cycle_idle) begin
                seen_busy_d = 1'b1;
            end else if (seen_busy_q) begin
                owe_pi_d    = 1'b0;
                seen_busy_d = 1'b0;
            end else begin
                seen_busy_d = seen_busy_q;
            end
        end else begin
            seen_busy_d = 1'b0;
        end
`endif
        case (state_q)
            ST_OWN: begin
                cnt_d = '0;
                if (!bgack_s) begin
                    state_d = ST_EXT;
                end else if (!br_s && !owe_pi_q) begin
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_OWN;
                end
            end
            ST_PEND: begin
                if (br_s) begin
                    state_d = ST_OWN;
                end else if (cycle_idle) begin
                    state_d = ST_GRANT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_GRANT: begin
                if (!bgack_s) begin
                    state_d = ST_EXT;
                    cnt_d   = '0;
                end else if (br_s && (cnt_q == GRANT_LIM)) begin
                    state_d = ST_OWN;
                    cnt_d   = '0;
                end else if (cnt_q != GRANT_LIM) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_EXT: begin
                cnt_d = '0;
                if (bgack_s) begin
                    state_d = ST_REC;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_EXT;
                end
            end
            ST_REC: begin
                if (!bgack_s) begin
                    state_d = ST_EXT;
                    cnt_d   = '0;
                end else if (cnt_q >= REC_LIM) begin
                    cnt_d = '0;
`ifdef M68K_ARB_FAIR_EN
                    if (op_req_pending) begin
                        state_d     = ST_OWN;
                        owe_pi_d    = 1'b1;
                        seen_busy_d = 1'b0;
                    end else if (!br_s) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_OWN;
                    end
`else
                    if (!br_s) begin
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_OWN;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_OWN;
                cnt_d   = '0;
            end
        endcase
    end

    assign bg_n         = bg_n_q;
    assign hold_req     = hold_req_q;
    assign bus_released = bus_released_q;
    assign arb_state    = arb_state_q;

endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Sits beside the 68K bus-cycle engine on the M68K side of the CPLD and implements 68000 bus arbitration (BR_n / BG_n / BGACK_n) for external masters such as Zorro DMA cards.
- Decides when the engine may start a cycle (`hold_req`) and when the CPLD must tristate its bus drivers (`bus_released`).
- Exports a 2-bit arbitration state for the Pi status register.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the BR_n/BGACK_n synchronisers (min 2).
- GRANT_TIMEOUT, 15: c7m cycles BG_n may stay asserted without BGACK_n before the grant is rescinded (when BR_n is already released).
- RECOVERY_CYCLES, 2: c7m cycles after BGACK_n negation before the CPLD drives the bus again.

Ports:
- c7m  in  1  M68K_CLK; all logic on its falling edge (negedge), as the bus-cycle engine.
- reset  in  1  synchronous, active-high.
- br_n  in  1  M68K_BR_n, raw.
- bgack_n  in  1  M68K_BGACK_n, raw.
- cycle_idle  in  1  high when the bus-cycle engine is in its idle state (state 0, no request pending/in flight).
- op_req_pending  in  1  Pi-side request waiting (op_req_sync); used only by the optional feature.
- bg_n  out  1  drives M68K_BG_n.
- hold_req  out  1  high: engine must not leave idle.
- bus_released  out  1  high: tristate AS/UDS/LDS/RW/FC/address and data latch OEs.
- arb_state  out  2  0 OWN, 1 PEND, 2 GRANT, 3 EXT; for status[15:14]-style readout.

Behaviour:
- Reset, applied on any c7m negedge with reset=1, from any state:
  - outputs: bg_n=1, hold_req=0, bus_released=0, arb_state=0.
  - FSM to OWN; counters cleared; synchronisers loaded with 1.
  - An external master mid-tenure is abandoned. Reset is only asserted together with M68K_RESET_n, which ends tenure.
- br_s / bgack_s: outputs of SYNC_STAGES synchronisers, active-low. All decisions use synchronised values, so latency from pin to decision is SYNC_STAGES cycles.
- OWN:
  - bg_n=1, hold_req=0, bus_released=0.
  - br_s=0 -> PEND.
  - bgack_s=0 while in OWN is a protocol error from a rogue master; treat it as EXT directly.
- PEND:
  - hold_req=1, bg_n=1.
  - Wait for cycle_idle=1, then -> GRANT next cycle.
  - br_s returns 1 before idle -> OWN (request withdrawn).
  - A cycle already in flight always completes; hold_req only blocks a new start.
- GRANT:
  - bg_n=0, hold_req=1, bus_released=1.
  - Timeout counter increments every cycle, saturating at GRANT_TIMEOUT.
  - bgack_s=0 -> EXT, counter cleared.
  - br_s=1 and counter==GRANT_TIMEOUT -> OWN (rescind; bg_n=1 in that same transition).
  - br_s=1 before the timeout: stay in GRANT, since BR may legally drop once BGACK is about to assert.
- EXT:
  - bg_n=1 (negated one cycle after bgack_s seen), hold_req=1, bus_released=1.
  - bgack_s=1 -> REC.
  - If br_s=0 again while bgack_s=0 (chained master), stay in EXT.
- REC (internal; arb_state reports 3):
  - hold_req=1, bus_released=1, bg_n=1.
  - Count RECOVERY_CYCLES.
  - At expiry: br_s=0 -> PEND, else OWN.
  - bgack_s=0 during REC -> EXT, counter cleared.
- Simultaneous events:
  - br_s=0 and bgack_s=0 in the same OWN cycle -> EXT; bgack has priority.
  - Reset has priority over everything.
- Counter width: $clog2(max(GRANT_TIMEOUT, RECOVERY_CYCLES)+1). Saturating; never wraps.
- bg_n, hold_req and bus_released are registered outputs, with no combinational path from pins.

Optional Feature:
- M68K_ARB_FAIR_EN.
- Defined:
  - Leaving REC with op_req_pending=1 goes to OWN regardless of br_s.
  - A 1-bit `owe_pi` flag set there blocks OWN->PEND until the engine completes one cycle, i.e. the cycle_idle falling-then-rising sequence is seen.
  - This guarantees the Pi at least one bus cycle between back-to-back DMA tenures.
  - `owe_pi` is cleared by reset.
- Undefined: no flag; REC exits as above; a persistent BR can starve the Pi.

Test Plan:
- Idle grant:
  - Stimulus: reset, cycle_idle=1, br_n 1->0.
  - Required: bg_n=0 exactly SYNC_STAGES+2 negedges later; bus_released=1; arb_state=2.
- Busy grant:
  - Stimulus: br_n=0 while cycle_idle=0 for 6 cycles.
  - Required: arb_state=1; hold_req=1; bg_n stays 1 until 1 cycle after cycle_idle=1.
- Full tenure:
  - Stimulus: grant, bgack_n=0 for 20 cycles, then 1.
  - Required: bg_n=1 one cycle after bgack_s=0; bus_released=1 throughout; bus_released=0 RECOVERY_CYCLES(2)+1 cycles after bgack_s=1.
- Rescind:
  - Stimulus: grant, br_n=1, bgack_n never asserted.
  - Required: bg_n returns 1 and arb_state=0 after exactly 15 GRANT-state cycles.
- Reset mid-EXT:
  - Stimulus: in EXT, reset=1 for 1 cycle.
  - Required: next cycle bg_n=1, hold_req=0, bus_released=0, arb_state=0.
- Fairness (M68K_ARB_FAIR_EN):
  - Stimulus: br_n held 0 across tenure end, op_req_pending=1.
  - Required: arb_state=0 and hold_req=0 until one engine cycle completes, then PEND. Without the macro: goes straight to PEND.
